// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, instruction-cache request port, fetch buffer
// toward decode, and redirect handling with discard of a stale in-flight
// response.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  cache_req,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_valid,
  input  logic [WORD_WIDTH-1:0] cache_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ins_valid,
  output logic [WORD_WIDTH-1:0] ins_data,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  input  logic                  ins_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam logic [LOG2_DEPTH:0]   DEPTH_C    = (LOG2_DEPTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    r_stale;
  logic                    r_cache_req;
  logic [ADDR_WIDTH-1:0]   r_cache_addr;

  logic [WORD_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   r_mem_pc   [FIFO_DEPTH];
  logic [LOG2_DEPTH-1:0]   r_wr_ptr;
  logic [LOG2_DEPTH-1:0]   r_rd_ptr;
  logic [LOG2_DEPTH:0]     r_count;

  logic                    w_redir_en;
  logic [ADDR_WIDTH-1:0]   w_redir_pc;
  logic                    w_issue;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_not_empty;

  // Redirect target is always word aligned; low bits are simply cleared.
  assign w_redir_en  = redirect_valid;
  assign w_redir_pc  = redirect_pc & ALIGN_MASK;
  assign w_not_empty = (r_count != '0);

  // Issue only when the buffer has room, so an accepted response always fits.
  assign w_issue  = (r_state == S_IDLE) && !w_redir_en && (r_count < DEPTH_C);
  assign w_accept = (r_state == S_WAIT) && cache_valid;
  // A redirect in the accept cycle discards the word: it belongs to the old stream.
  assign w_push   = w_accept && !r_stale && !w_redir_en;
  // Redirect flushes the buffer, so a pop in the same cycle is meaningless.
  assign w_pop    = w_not_empty && ins_ready && !w_redir_en;

  assign cache_req  = r_cache_req;
  assign cache_addr = r_cache_addr;
  assign ins_valid  = w_not_empty;
  assign ins_data   = w_not_empty ? r_mem_data[r_rd_ptr] : '0;
  assign ins_pc     = w_not_empty ? r_mem_pc[r_rd_ptr]   : '0;

  // Fetch FSM: PC, stale tracking and registered cache request/address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_stale      <= 1'b0;
      r_cache_req  <= 1'b0;
      r_cache_addr <= RESET_PC;
    end else begin
      r_cache_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_redir_en) begin
            r_pc <= w_redir_pc;
          end else if (w_issue) begin
            r_cache_req  <= 1'b1;
            r_cache_addr <= r_pc;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cache_valid) begin
            // Transaction closes; any stale marker is consumed by this response.
            r_state <= S_IDLE;
            r_stale <= 1'b0;
            if (w_redir_en) begin
              r_pc <= w_redir_pc;
            end else if (!r_stale) begin
              r_pc <= r_pc + PC_STEP;
            end
          end else if (w_redir_en) begin
            // The outstanding cache access cannot be cancelled; drop it on return.
            r_pc    <= w_redir_pc;
            r_stale <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fetch buffer pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || w_redir_en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Fetch buffer storage: instruction word with the address it came from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= cache_data;
      r_mem_pc[r_wr_ptr]   <= r_cache_addr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Count delivered fetches and cycles spent waiting on the cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push) r_perf_fetch <= sat_inc(r_perf_fetch);
      if ((r_state == S_WAIT) && !cache_valid) r_perf_stall <= sat_inc(r_perf_stall);
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable cache model.
// Cache model returns data = address + 0x1000_0000.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        cache_req;
  logic [31:0] cache_addr;
  logic        cache_valid;
  logic [31:0] cache_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .cache_req      (cache_req),
    .cache_addr     (cache_addr),
    .cache_valid    (cache_valid),
    .cache_data     (cache_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cache model: answers each request 'lat' cycles after the request cycle.
  initial begin
    bit pend;
    int cnt;
    pend = 0;
    cnt = 0;
    cache_valid = 1'b0;
    cache_data = '0;
    forever begin
      @(negedge clk);
      cache_valid = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            cache_valid = 1'b1;
            cache_data = cache_addr + 32'h1000_0000;
            pend = 0;
          end else begin
            cnt--;
          end
        end
        if (cache_req) begin
          pend = 1;
          cnt = lat - 1;
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b expected 0", cache_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_ins_valid: got %0b expected 0", ins_valid); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %08h expected 00000000", cache_addr); end
    checks++; if (ins_data !== 32'h0) begin errors++; $display("FAIL rst_ins_data: got %08h expected 00000000", ins_data); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL rst_ins_pc: got %08h expected 00000000", ins_pc); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cache_req !== 1'b1) begin errors++; $display("FAIL first_issue_req: got %0b expected 1", cache_req); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL first_issue_addr: got %08h expected 00000000", cache_addr); end
  endtask

  task automatic test_hits;
    logic [31:0] exp_pc [3];
    logic [31:0] got_pc [3];
    logic [31:0] got_dat[3];
    int n;
    exp_pc = '{32'h4, 32'h8, 32'hC};
    @(negedge clk);
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL hit_lat_valid_early: got %0b expected 0", ins_valid); end
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL hit_req_pulse: got %0b expected 0", cache_req); end
    @(negedge clk);
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL hit_lat_valid: got %0b expected 1", ins_valid); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL hit_pc0: got %08h expected 00000000", ins_pc); end
    checks++; if (ins_data !== 32'h1000_0000) begin errors++; $display("FAIL hit_data0: got %08h expected 10000000", ins_data); end
    @(negedge clk);
    checks++; if (cache_req !== 1'b1) begin errors++; $display("FAIL hit_reissue_req: got %0b expected 1", cache_req); end
    checks++; if (cache_addr !== 32'h4) begin errors++; $display("FAIL hit_reissue_addr: got %08h expected 00000004", cache_addr); end
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clk);
      if (ins_valid && ins_ready) begin
        got_pc[n] = ins_pc;
        got_dat[n] = ins_data;
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL hit_count: got %0d deliveries expected 3", n);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (got_pc[k] !== exp_pc[k]) begin errors++; $display("FAIL hit_pc[%0d]: got %08h expected %08h", k, got_pc[k], exp_pc[k]); end
        checks++; if (got_dat[k] !== exp_pc[k] + 32'h1000_0000) begin errors++; $display("FAIL hit_data[%0d]: got %08h expected %08h", k, got_dat[k], exp_pc[k] + 32'h1000_0000); end
      end
    end
  endtask

  task automatic test_backpressure;
    int nreq;
    @(negedge clk);
    ins_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      if (cache_req) nreq++;
      @(negedge clk);
    end
    checks++; if (nreq != 4) begin errors++; $display("FAIL bp_issues_to_full: got %0d expected 4", nreq); end
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", ins_valid); end
    checks++; if (ins_pc !== 32'h200) begin errors++; $display("FAIL bp_head_pc: got %08h expected 00000200", ins_pc); end
    checks++; if (ins_data !== 32'h1000_0200) begin errors++; $display("FAIL bp_head_data: got %08h expected 10000200", ins_data); end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      if (cache_req) nreq++;
      @(negedge clk);
    end
    checks++; if (nreq != 1) begin errors++; $display("FAIL bp_one_pop_one_issue: got %0d expected 1", nreq); end
    checks++; if (ins_pc !== 32'h204) begin errors++; $display("FAIL bp_head_after_pop: got %08h expected 00000204", ins_pc); end
  endtask

  task automatic test_redirect_miss;
    bit seen;
    bit leaked;
    lat = 4;
    ins_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cache_req) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL miss_issue_timeout: got no request expected one"); end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    seen = 0;
    leaked = 0;
    for (int i = 0; i < 20; i++) begin
      if (cache_req) begin seen = 1; break; end
      if (ins_valid) leaked = 1;
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL miss_reissue_timeout: got no request expected one"); end
    checks++; if (leaked) begin errors++; $display("FAIL miss_fifo_empty: got ins_valid=1 expected 0 before new fetch"); end
    checks++; if (cache_addr !== 32'h100) begin errors++; $display("FAIL miss_new_addr: got %08h expected 00000100", cache_addr); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ins_valid) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL miss_deliver_timeout: got none expected 00000100"); end
    checks++; if (ins_pc !== 32'h100) begin errors++; $display("FAIL miss_first_pc: got %08h expected 00000100", ins_pc); end
    checks++; if (ins_data !== 32'h1000_0100) begin errors++; $display("FAIL miss_first_data: got %08h expected 10000100", ins_data); end
    lat = 1;
  endtask

  task automatic test_simultaneous;
    bit seen;
    @(negedge clk);
    ins_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cache_req && ins_valid) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL sim_setup_timeout: got no req with valid head expected one"); end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    ins_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL sim_flush: got ins_valid=%0b expected 0", ins_valid); end
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL sim_no_issue: got %0b expected 0", cache_req); end
    @(negedge clk);
    checks++; if (cache_req !== 1'b1) begin errors++; $display("FAIL sim_issue_no_stale: got %0b expected 1", cache_req); end
    checks++; if (cache_addr !== 32'h300) begin errors++; $display("FAIL sim_addr: got %08h expected 00000300", cache_addr); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ins_valid) begin seen = 1; break; end
    end
    checks++; if (!seen || ins_pc !== 32'h300) begin errors++; $display("FAIL sim_first_pc: got %08h (valid %0b) expected 00000300", ins_pc, seen); end
  endtask

  task automatic test_wrap;
    logic [31:0] got_pc [2];
    logic [31:0] got_dat[2];
    int n;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf;
    logic [31:0] ps;
    pf = '0;
    ps = '0;
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cache_req !== 1'b0 || ins_valid !== 1'b0) begin errors++; $display("FAIL wrap_reset: got req=%0b valid=%0b expected 0 0", cache_req, ins_valid); end
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    ins_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (cache_req !== 1'b0) begin errors++; $display("FAIL wrap_no_issue_on_redirect: got %0b expected 0", cache_req); end
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (ins_valid && ins_ready) begin
        got_pc[n] = ins_pc;
        got_dat[n] = ins_data;
`ifdef FETCH_PERF_CNT_EN
        pf = perf_fetch_cnt;
        ps = perf_stall_cnt;
`endif
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL wrap_count: got %0d deliveries expected 2", n);
    end else begin
      checks++; if (got_pc[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %08h expected fffffffc", got_pc[0]); end
      checks++; if (got_dat[0] !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_data0: got %08h expected 0ffffffc", got_dat[0]); end
      checks++; if (got_pc[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %08h expected 00000000", got_pc[1]); end
      checks++; if (got_dat[1] !== 32'h1000_0000) begin errors++; $display("FAIL wrap_data1: got %08h expected 10000000", got_dat[1]); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (pf !== 32'd2) begin errors++; $display("FAIL perf_fetch: got %0d expected 2", pf); end
      checks++; if (ps !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", ps); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ins_ready = 1'b1;
    test_reset();
    test_hits();
    test_backpressure();
    test_redirect_miss();
    test_simultaneous();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
